// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the pwm_multi peripheral: register word offsets,
// CTRL bit positions and the packed CTRL view used for readback.
package pwm_multi_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_PRESC     = 1;
    localparam int REG_PERIOD    = 2;
    localparam int REG_POL       = 3;
    localparam int REG_CNT       = 4;
    localparam int REG_DUTY_BASE = 5;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_FLAG = 2;

    // Member order places en at bit 0, ie at bit 1 and flag at bit 2.
    typedef struct packed {
        logic flag;
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {29'd0, c};
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Word-addressed peripheral bus: one-cycle write strobe, combinational read data.
interface pwm_multi_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] A;
    logic [31:0]       WD;
    logic              WE;
    logic [31:0]       RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/pwm_multi_channel.sv
// One PWM compare channel: double-buffered duty, compare against the shared
// counter, polarity and the registered output.
module pwm_multi_channel
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             period_end,
    input  logic             run,
    input  logic             pol,
    input  logic             we_sel,
    input  logic [CNT_W-1:0] wd,
    output logic [CNT_W-1:0] duty_sh,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;
    logic             raw;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        if (we_sel) begin
            duty_sh_d = wd;
        end
        // The active copy only sees the shadow value held before this cycle,
        // so a write landing on the period end waits one more period.
        if (!run || period_end) begin
            duty_act_d = duty_sh_q;
        end
        raw   = (cnt < duty_act_q);
        pwm_d = run ? (raw ^ pol) : pol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_sh = duty_sh_q;
    assign pwm     = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: bus decode, shared prescaler and period
// counter, period-end flag and interrupt; compare logic sits in each channel.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int          CH         = 4,
    parameter int          CNT_W      = 16,
    parameter int          PRE_W      = 16,
    parameter int          ADDR_W     = 4,
    parameter int unsigned PRESC_RST  = 1332,
    parameter int unsigned PERIOD_RST = 100
) (
    input  logic          clk,
    input  logic          reset,
    pwm_multi_if.slave    bus,
    output logic [CH-1:0] pwm_out,
    output logic          irq
);

    logic [ADDR_W-1:0] addr;

    logic en_q, en_d;
    logic ie_q, ie_d;
    logic flag_q, flag_d;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]    pol_q, pol_d;

    logic          wr_ctrl, wr_presc, wr_period, wr_pol;
    logic [CH-1:0] wr_duty;
    logic          run, tick, period_end;

    logic [CNT_W-1:0] duty_sh [CH];
    ctrl_t            ctrl_view;
    logic             unused_wd;

    assign addr      = bus.A;
    assign unused_wd = ^bus.WD;

    always_comb begin
        wr_ctrl   = bus.WE && (addr == ADDR_W'(REG_CTRL));
        wr_presc  = bus.WE && (addr == ADDR_W'(REG_PRESC));
        wr_period = bus.WE && (addr == ADDR_W'(REG_PERIOD));
        wr_pol    = bus.WE && (addr == ADDR_W'(REG_POL));
        wr_duty   = '0;
        for (int i = 0; i < CH; i++) begin
            wr_duty[i] = bus.WE && (addr == ADDR_W'(REG_DUTY_BASE + i));
        end
    end

    always_comb begin
        en_d        = en_q;
        ie_d        = ie_q;
        presc_d     = presc_q;
        period_sh_d = period_sh_q;
        pol_d       = pol_q;
        if (wr_ctrl) begin
            en_d = bus.WD[CTRL_EN];
            ie_d = bus.WD[CTRL_IE];
        end
        if (wr_presc) begin
            presc_d = bus.WD[PRE_W-1:0];
        end
        if (wr_period) begin
            period_sh_d = bus.WD[CNT_W-1:0];
        end
        if (wr_pol) begin
            pol_d = bus.WD[CH-1:0];
        end
    end

    // Counting needs EN both before and after this edge: an enabling write
    // starts from cleared counters, a disabling write stops at once.
    always_comb begin
        run        = en_q && en_d;
        tick       = run && (pre_cnt_q == presc_q);
        period_end = tick && (cnt_q == period_act_q);

        pre_cnt_d = pre_cnt_q + 1'b1;
        if (!run || tick || wr_presc) begin
            pre_cnt_d = '0;
        end

        cnt_d = cnt_q;
        if (!run || period_end) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        period_act_d = period_act_q;
        if (!run || period_end) begin
            period_act_d = period_sh_q;
        end

        // A clear coinciding with a period end loses to the set.
        flag_d = flag_q;
        if (wr_ctrl && bus.WD[CTRL_FLAG]) begin
            flag_d = 1'b0;
        end
        if (period_end) begin
            flag_d = 1'b1;
        end
    end

    always_comb begin
        ctrl_view.flag = flag_q;
        ctrl_view.ie   = ie_q;
        ctrl_view.en   = en_q;
        bus.RD         = '0;
        case (addr)
            ADDR_W'(REG_CTRL):   bus.RD = ctrl_word(ctrl_view);
            ADDR_W'(REG_PRESC):  bus.RD = 32'(presc_q);
            ADDR_W'(REG_PERIOD): bus.RD = 32'(period_sh_q);
            ADDR_W'(REG_POL):    bus.RD = 32'(pol_q);
            ADDR_W'(REG_CNT):    bus.RD = 32'(cnt_q);
            default: begin
                for (int i = 0; i < CH; i++) begin
                    if (addr == ADDR_W'(REG_DUTY_BASE + i)) begin
                        bus.RD = 32'(duty_sh[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            ie_q         <= 1'b0;
            flag_q       <= 1'b0;
            presc_q      <= PRE_W'(PRESC_RST);
            pre_cnt_q    <= '0;
            period_sh_q  <= CNT_W'(PERIOD_RST);
            period_act_q <= CNT_W'(PERIOD_RST);
            cnt_q        <= '0;
            pol_q        <= '0;
        end else begin
            en_q         <= en_d;
            ie_q         <= ie_d;
            flag_q       <= flag_d;
            presc_q      <= presc_d;
            pre_cnt_q    <= pre_cnt_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            pol_q        <= pol_d;
        end
    end

    assign irq = flag_q & ie_q;

    // Polarity is taken from the next-state value so a POL write shows on the
    // following edge.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_multi_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cnt        (cnt_q),
            .period_end (period_end),
            .run        (run),
            .pol        (pol_d[i]),
            .we_sel     (wr_duty[i]),
            .wd         (bus.WD[CNT_W-1:0]),
            .duty_sh    (duty_sh[i]),
            .pwm        (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized runs
// compared against closed-form timing of counter, duty, outputs and flag.
module tb_pwm_multi;
    import pwm_multi_pkg::*;

    localparam int CH     = 4;
    localparam int CNT_W  = 16;
    localparam int PRE_W  = 16;
    localparam int ADDR_W = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] pwm_out;
    logic          irq;

    pwm_multi_if #(.ADDR_W(ADDR_W)) bus ();

    pwm_multi #(
        .CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .ADDR_W(ADDR_W),
        .PRESC_RST(1332), .PERIOD_RST(100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state; cycle 0 is the first cycle after the enabling write.
    int            m_p, m_n, m_plen;
    logic [CH-1:0] m_pol;
    int            init_duty [CH];
    int            log_ch[$], log_cyc[$], log_val[$];
    int            last_clear;

    function automatic int exp_cnt(input int j);
        if (j < 0) return 0;
        return (j / (m_p + 1)) % (m_n + 1);
    endfunction

    // Duty active during period k: a write in cycle w applies from period (w+1)/P + 1.
    function automatic int exp_duty(input int ch, input int k);
        int d;
        d = init_duty[ch];
        foreach (log_ch[e]) begin
            if (log_ch[e] == ch && ((log_cyc[e] + 1) / m_plen + 1) <= k) d = log_val[e];
        end
        return d;
    endfunction

    function automatic logic exp_pwm(input int ch, input int j);
        logic r;
        if (j <= 0) return m_pol[ch];
        r = (exp_cnt(j - 1) < exp_duty(ch, (j - 1) / m_plen));
        return r ^ m_pol[ch];
    endfunction

    function automatic logic [CH-1:0] exp_vec(input int j);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = exp_pwm(c, j);
        return v;
    endfunction

    // Period ends fall in cycles m*P-1; FLAG is visible from the cycle after.
    function automatic logic exp_flag(input int j);
        int m;
        m = j / m_plen;
        if (m < 1) return 1'b0;
        return (last_clear <= m * m_plen - 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.A  = ADDR_W'(a);
        bus.WD = 32'(d);
        bus.WE = 1'b1;
        cyc();
        bus.WE = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        bus.A = ADDR_W'(a);
        #1;
        v = bus.RD;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bus.WE = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        log_ch.delete();
        log_cyc.delete();
        log_val.delete();
        last_clear = -100;
    endtask

    task automatic start(input int p, input int n, input logic [CH-1:0] pol, input int ctrl);
        m_p    = p;
        m_n    = n;
        m_plen = (p + 1) * (n + 1);
        m_pol  = pol;
        wr(REG_PRESC, p);
        wr(REG_PERIOD, n);
        wr(REG_POL, int'(pol));
        for (int c = 0; c < CH; c++) wr(REG_DUTY_BASE + c, init_duty[c]);
        wr(REG_CTRL, ctrl);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int          exp_rd [16];
        do_reset();
        exp_rd = '{0, 1332, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        n_cmp++;
        if (pwm_out !== '0) begin n_err++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq); end
        for (int a = 0; a < 16; a++) begin
            rd(a, v);
            n_cmp++;
            if (v !== 32'(exp_rd[a])) begin
                n_err++;
                $display("FAIL reset_reg[%0d] got=%0d want=%0d", a, v, exp_rd[a]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        int          highs;
        do_reset();
        init_duty = '{3, 0, 0, 0};
        start(0, 9, '0, 1);
        highs = 0;
        for (int j = 0; j < 40; j++) begin
            rd(REG_CTRL, v);
            n_cmp++;
            if (pwm_out[0] !== exp_pwm(0, j)) begin
                n_err++; $display("FAIL basic_pwm0 cyc=%0d got=%b want=%b", j, pwm_out[0], exp_pwm(0, j));
            end
            n_cmp++;
            if (v[CTRL_FLAG] !== exp_flag(j)) begin
                n_err++; $display("FAIL basic_flag cyc=%0d got=%b want=%b", j, v[CTRL_FLAG], exp_flag(j));
            end
            if (j >= 11 && j <= 20 && pwm_out[0] === 1'b1) highs++;
            if (j == 12 || j == 29) begin
                bus.A = ADDR_W'(REG_CTRL); bus.WD = 32'h5; bus.WE = 1'b1; last_clear = j;
            end
            cyc();
            bus.WE = 1'b0;
        end
        n_cmp++;
        if (highs !== 3) begin n_err++; $display("FAIL basic_high_count got=%0d want=3", highs); end
    endtask

    task automatic test_extremes();
        do_reset();
        init_duty = '{0, 10, 0, 0};
        start(0, 9, '0, 1);
        for (int j = 0; j < 46; j++) begin
            #1;
            n_cmp++;
            if (pwm_out[0] !== 1'b0) begin n_err++; $display("FAIL ext_ch0 cyc=%0d got=%b want=0", j, pwm_out[0]); end
            if (j < 26) begin
                n_cmp++;
                if (pwm_out[1] !== exp_pwm(1, j)) begin
                    n_err++; $display("FAIL ext_ch1 cyc=%0d got=%b want=%b", j, pwm_out[1], exp_pwm(1, j));
                end
            end else begin
                n_cmp++;
                if (pwm_out[1] !== 1'b0) begin n_err++; $display("FAIL ext_ch1_pol cyc=%0d got=%b want=0", j, pwm_out[1]); end
            end
            if (j == 25) begin
                bus.A = ADDR_W'(REG_POL); bus.WD = 32'h2; bus.WE = 1'b1;
            end
            cyc();
            bus.WE = 1'b0;
        end
    endtask

    task automatic test_shadow();
        logic [31:0] v;
        do_reset();
        init_duty = '{3, 0, 0, 0};
        start(0, 9, '0, 1);
        for (int j = 0; j < 50; j++) begin
            rd(REG_CNT, v);
            n_cmp++;
            if (v !== 32'(exp_cnt(j))) begin n_err++; $display("FAIL shadow_cnt cyc=%0d got=%0d want=%0d", j, v, exp_cnt(j)); end
            n_cmp++;
            if (pwm_out[0] !== exp_pwm(0, j)) begin
                n_err++; $display("FAIL shadow_pwm0 cyc=%0d got=%b want=%b", j, pwm_out[0], exp_pwm(0, j));
            end
            if (j == 4 || j == 19) begin
                bus.A = ADDR_W'(REG_DUTY_BASE); bus.WD = (j == 4) ? 32'd7 : 32'd5; bus.WE = 1'b1;
                log_ch.push_back(0); log_cyc.push_back(j); log_val.push_back((j == 4) ? 7 : 5);
            end
            cyc();
            bus.WE = 1'b0;
        end
        rd(REG_DUTY_BASE, v);
        n_cmp++;
        if (v !== 32'd5) begin n_err++; $display("FAIL shadow_readback got=%0d want=5", v); end
    endtask

    task automatic run_random(input int p, input int n, input int cycles, input bit do_writes, output int max_cnt);
        logic [31:0]   v;
        logic [CH-1:0] ev;
        max_cnt = 0;
        for (int j = 0; j < cycles; j++) begin
            rd(REG_CNT, v);
            if (int'(v) > max_cnt) max_cnt = int'(v);
            n_cmp++;
            if (v !== 32'(exp_cnt(j))) begin n_err++; $display("FAIL rand_cnt p=%0d n=%0d cyc=%0d got=%0d want=%0d", p, n, j, v, exp_cnt(j)); end
            ev = exp_vec(j);
            n_cmp++;
            if (pwm_out !== ev) begin n_err++; $display("FAIL rand_pwm p=%0d n=%0d cyc=%0d got=%b want=%b", p, n, j, pwm_out, ev); end
            if (do_writes && $urandom_range(0, 7) == 0) begin
                automatic int c = $urandom_range(0, CH - 1);
                automatic int d = $urandom_range(0, n + 2);
                bus.A = ADDR_W'(REG_DUTY_BASE + c); bus.WD = 32'(d); bus.WE = 1'b1;
                log_ch.push_back(c); log_cyc.push_back(j); log_val.push_back(d);
            end
            cyc();
            bus.WE = 1'b0;
        end
    endtask

    task automatic test_presc();
        int mx;
        do_reset();
        for (int c = 0; c < CH; c++) init_duty[c] = $urandom_range(0, 6);
        start(2, 4, CH'($urandom), 1);
        run_random(2, 4, 60, 1'b0, mx);
        n_cmp++;
        if (mx !== 4) begin n_err++; $display("FAIL presc_cnt_max got=%0d want=4", mx); end
    endtask

    task automatic test_random();
        int p, n, mx;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            p = $urandom_range(0, 3);
            n = $urandom_range(1, 12);
            for (int c = 0; c < CH; c++) init_duty[c] = $urandom_range(0, n + 2);
            start(p, n, CH'($urandom), 1);
            run_random(p, n, 90, 1'b1, mx);
        end
    endtask

    task automatic test_flag_irq();
        do_reset();
        init_duty = '{2, 0, 0, 0};
        start(0, 4, '0, 3);
        for (int j = 0; j < 25; j++) begin
            #1;
            n_cmp++;
            if (irq !== exp_flag(j)) begin n_err++; $display("FAIL irq cyc=%0d got=%b want=%b", j, irq, exp_flag(j)); end
            if (j == 7 || j == 14) begin
                bus.A = ADDR_W'(REG_CTRL); bus.WD = 32'h7; bus.WE = 1'b1; last_clear = j;
            end
            cyc();
            bus.WE = 1'b0;
        end
    endtask

    task automatic test_disable();
        logic [31:0]   v;
        logic [CH-1:0] pol;
        do_reset();
        init_duty = '{5, 2, 9, 11};
        pol = CH'($urandom);
        start(0, 9, pol, 1);
        for (int j = 0; j < 7; j++) begin
            #1;
            n_cmp++;
            if (pwm_out !== exp_vec(j)) begin n_err++; $display("FAIL dis_run cyc=%0d got=%b want=%b", j, pwm_out, exp_vec(j)); end
            cyc();
        end
        wr(REG_CTRL, 0);
        for (int k = 0; k < 6; k++) begin
            rd(REG_CNT, v);
            n_cmp++;
            if (v !== 32'd0) begin n_err++; $display("FAIL dis_cnt k=%0d got=%0d want=0", k, v); end
            n_cmp++;
            if (pwm_out !== pol) begin n_err++; $display("FAIL dis_pwm k=%0d got=%b want=%b", k, pwm_out, pol); end
            cyc();
        end
        rd(REG_CTRL, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL dis_ctrl got=%0d want=0", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        do_reset();
        init_duty = '{5, 0, 0, 0};
        start(0, 9, 4'b0011, 1);
        cyc();
        cyc();
        cyc();
        reset  = 1'b1;
        bus.A  = ADDR_W'(REG_PERIOD);
        bus.WD = 32'd55;
        bus.WE = 1'b1;
        cyc();
        reset  = 1'b0;
        bus.WE = 1'b0;
        n_cmp++;
        if (pwm_out !== '0) begin n_err++; $display("FAIL rstmid_pwm got=%b want=0", pwm_out); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq got=%b want=0", irq); end
        rd(REG_CNT, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d want=0", v); end
        rd(REG_PRESC, v);
        n_cmp++;
        if (v !== 32'd1332) begin n_err++; $display("FAIL rstmid_presc got=%0d want=1332", v); end
        rd(REG_PERIOD, v);
        n_cmp++;
        if (v !== 32'd100) begin n_err++; $display("FAIL rstmid_period got=%0d want=100", v); end
        rd(REG_CTRL, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL rstmid_ctrl got=%0d want=0", v); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        bus.A  = '0;
        bus.WD = '0;
        bus.WE = 1'b0;
        last_clear = -100;
        m_p = 0; m_n = 1; m_plen = 2; m_pol = '0;
        for (int c = 0; c < CH; c++) init_duty[c] = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_shadow();
        test_presc();
        test_random();
        test_flag_irq();
        test_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM peripheral on the memory-mapped peripheral bus of the multi-cycle RISC-V core.
- One shared prescaler and period counter drive CH compare channels.
- Each channel has its own duty cycle, output polarity and enable gating.
- Period and duty writes are double-buffered and take effect only at a period boundary, so outputs never glitch.
- A period-end flag with optional interrupt lets software resynchronise.

Parameters:
- CH, 4: number of PWM channels (1..11).
- CNT_W, 16: width of the period counter, PERIOD register and DUTY registers.
- PRE_W, 16: width of the prescaler counter and PRESC register.
- ADDR_W, 4: width of the word-address input.
- PRESC_RST, 1332: reset value of PRESC.
- PERIOD_RST, 100: reset value of PERIOD. Together with PRESC_RST this gives the legacy 1 kHz, 0..100 % behaviour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- A  in  ADDR_W  word offset of the register access
- WD  in  32  write data
- WE  in  1  write strobe, one cycle per write
- RD  out  32  read data, combinational from A
- pwm_out  out  CH  PWM outputs; bit i is channel i
- irq  out  1  interrupt request, equal to FLAG & IE

Behaviour:
- Register map (word offsets):
  - 0 CTRL: bit0 EN, bit1 IE, bit2 FLAG (write 1 to clear).
  - 1 PRESC [PRE_W-1:0].
  - 2 PERIOD [CNT_W-1:0], shadow register.
  - 3 POL [CH-1:0].
  - 4 CNT, read-only, returns the live counter.
  - 5+i DUTY_i [CNT_W-1:0], shadow register.
- Reads of unmapped offsets return 0. Unused upper bits read 0. Writes to CNT or unmapped offsets are ignored.
- Reset values:
  - EN, IE, FLAG = 0; POL = 0; all DUTY = 0.
  - PRESC = PRESC_RST; PERIOD = PERIOD_RST.
  - Prescaler counter and CNT = 0.
  - pwm_out = 0; irq = 0.
- Prescaler:
  - pre_cnt increments every clk.
  - When pre_cnt == PRESC: tick = 1 and pre_cnt returns to 0. Tick rate is clk / (PRESC+1).
  - A write to PRESC loads the new value and clears pre_cnt in the same cycle.
- Period counter:
  - On each tick, CNT increments, or wraps to 0 when CNT == PERIOD_act.
  - The period is therefore PERIOD_act+1 ticks.
  - PERIOD_act and DUTY_act are the active copies of the shadow registers.
- Period end: tick && CNT == PERIOD_act. On that cycle:
  - CNT becomes 0.
  - Every active copy loads from its shadow register.
  - FLAG is set.
- Shadow timing:
  - A shadow write coinciding with period end does NOT reach the active copy. It takes effect at the next period end.
  - A FLAG clear coinciding with period end: the set wins, FLAG = 1.
- Compare: raw_i = (CNT < DUTY_act_i).
  - DUTY = 0 gives a constant 0.
  - DUTY > PERIOD_act gives a constant 1 (100 %).
- Output:
  - pwm_out[i] is registered as raw_i XOR POL[i], one clk after CNT changes.
  - A POL change is visible on the next clk edge.
- Disabled (EN = 0):
  - pre_cnt and CNT are held at 0.
  - Active copies track the shadows every cycle.
  - pwm_out[i] = POL[i], the inactive level.
  - FLAG is not set.
- Enable edge (EN 0 -> 1): the first tick occurs PRESC+1 cycles after the enabling write, starting from the current shadow values.
- Disable mid-period: outputs reach the inactive level on the cycle after the EN = 0 write; the counters clear.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of WE.

Decomposition:
- Shared header pwm_defs.vh holds:
  - register offset localparams (CTRL, PRESC, PERIOD, POL, CNT, DUTY_BASE);
  - CTRL bit positions (EN, IE, FLAG).
- Sub-module pwm_channel, instantiated CH times. It contains the DUTY shadow and active registers, the compare, polarity and the output register. Inputs: CNT, period_end, en, WE/select, WD.
- The top level owns the bus decode, prescaler, counter and flag/irq logic.

Test Plan:
1. Reset, then EN = 1 with PRESC = 0, PERIOD = 9, DUTY_0 = 3 -> pwm_out[0] is high 3 clks and low 7 clks, repeating every 10 clks; FLAG sets every 10 clks.
2. DUTY_0 = 0 and DUTY_1 = 10 with PERIOD = 9 -> ch0 constant 0 and ch1 constant 1 for full periods; POL[1] = 1 -> ch1 constant 0.
3. Write DUTY_0 = 7 mid-period (CNT = 4), then again on the exact period-end cycle -> the current period keeps the old duty; the new duty is visible from the following or next-following period respectively.
4. PRESC = 2, PERIOD = 4 -> ticks every 3 clks; period = 15 clks; CNT readback goes 0..4.
5. IE = 1: on period end irq = 1; write CTRL with bit2 = 1 -> irq = 0 next cycle; a clear on the period-end cycle leaves FLAG = 1.
6. Assert reset mid-period with EN = 1 -> next cycle pwm_out = 0, CNT = 0, PRESC reads 1332, PERIOD reads 100.
